// File: rtl/scr1_dmem_router.sv
// Data-memory router: steers core requests to the memory port (0) or timer port (1)
// by address decode and returns the response of the port holding the outstanding access.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_router_pkg;
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_router
  import scr1_dmem_router_pkg::*;
#(
  parameter logic [`SCR1_DMEM_AWIDTH-1:0] SCR1_PORT1_ADDR_MASK    = 32'hFFFF_FFE0,
  parameter logic [`SCR1_DMEM_AWIDTH-1:0] SCR1_PORT1_ADDR_PATTERN = 32'hF000_0040
) (
  input  logic                          clk,
  input  logic                          rst,
  // core side
  input  logic                          dmem_req,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_width_e          dmem_width,
  input  logic [`SCR1_DMEM_AWIDTH-1:0]  dmem_addr,
  input  logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_wdata,
  output logic                          dmem_req_ack,
  output logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp,
  // port 0: memory
  input  logic                          port0_req_ack,
  output logic                          port0_req,
  output type_scr1_mem_cmd_e            port0_cmd,
  output type_scr1_mem_width_e          port0_width,
  output logic [`SCR1_DMEM_AWIDTH-1:0]  port0_addr,
  output logic [`SCR1_DMEM_DWIDTH-1:0]  port0_wdata,
  input  logic [`SCR1_DMEM_DWIDTH-1:0]  port0_rdata,
  input  type_scr1_mem_resp_e           port0_resp,
  // port 1: timer
  input  logic                          port1_req_ack,
  output logic                          port1_req,
  output type_scr1_mem_cmd_e            port1_cmd,
  output type_scr1_mem_width_e          port1_width,
  output logic [`SCR1_DMEM_AWIDTH-1:0]  port1_addr,
  output logic [`SCR1_DMEM_DWIDTH-1:0]  port1_wdata,
  input  logic [`SCR1_DMEM_DWIDTH-1:0]  port1_rdata,
  input  type_scr1_mem_resp_e           port1_resp
);

  typedef enum logic {
    ST_ADDR = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  state_e                        state_reg, state_next;
  logic                          port_sel_reg, port_sel_next;
  logic                          port_sel;
  logic                          sel_ack;
  type_scr1_mem_resp_e           sel_resp;
  logic [`SCR1_DMEM_DWIDTH-1:0]  sel_rdata;

  assign port_sel  = ((dmem_addr & SCR1_PORT1_ADDR_MASK) == SCR1_PORT1_ADDR_PATTERN);
  assign sel_ack   = port_sel     ? port1_req_ack : port0_req_ack;
  assign sel_resp  = port_sel_reg ? port1_resp    : port0_resp;
  assign sel_rdata = port_sel_reg ? port1_rdata   : port0_rdata;

  assign port0_cmd   = dmem_cmd;
  assign port0_width = dmem_width;
  assign port0_addr  = dmem_addr;
  assign port0_wdata = dmem_wdata;
  assign port1_cmd   = dmem_cmd;
  assign port1_width = dmem_width;
  assign port1_addr  = dmem_addr;
  assign port1_wdata = dmem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_ADDR;
      port_sel_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      port_sel_reg <= port_sel_next;
    end
  end

  // Reset forces ADDR behaviour so a pending slave response can never leak to the core.
  always_comb begin
    port0_req     = 1'b0;
    port1_req     = 1'b0;
    dmem_req_ack  = 1'b0;
    dmem_resp     = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata    = '0;
    state_next    = state_reg;
    port_sel_next = port_sel_reg;

    if (rst || (state_reg == ST_ADDR)) begin
      port0_req    = dmem_req & ~port_sel;
      port1_req    = dmem_req &  port_sel;
      dmem_req_ack = sel_ack;
      if (dmem_req && sel_ack) begin
        state_next    = ST_DATA;
        port_sel_next = port_sel;
      end
    end else if (sel_resp != SCR1_MEM_RESP_NOTRDY) begin
      // response cycle: forward it and route a new request in the same cycle
      dmem_resp    = sel_resp;
      dmem_rdata   = sel_rdata;
      port0_req    = dmem_req & ~port_sel;
      port1_req    = dmem_req &  port_sel;
      dmem_req_ack = sel_ack;
      if (dmem_req && sel_ack) begin
        state_next    = ST_DATA;
        port_sel_next = port_sel;
      end else begin
        state_next    = ST_ADDR;
      end
    end
  end

endmodule
